uart_rx_fsmd: RTL and testbench
===============================

Name: uart_rx_fsmd

Overview:
UART receiver, the receive-side counterpart of the UART transmitter, built as controller plus datapath in a single module. It oversamples the serial line at no_of_clks clocks per bit and detects the start bit. Data bits are sampled at mid-bit, LSB first, followed by optional parity and one stop bit. The received word is presented with a 1-cycle valid pulse plus parity and framing error flags.

Parameters:
data_size, 8, number of data bits per frame (1..8)
parity_on, 1, 1 = parity bit expected between data and stop; 0 = no parity bit
even_parity, 1, 1 = even parity check; 0 = odd parity check (ignored when parity_on=0)
no_of_clks, 16, clk cycles per bit; even, >= 4
sampling_cntr_width, 4, sampling counter width; must hold no_of_clks-1

Ports:
clk  input  1  oversampling clock (BAUD_RATE*no_of_clks)
rst  input  1  global asynchronous reset, active-high
Rx_s  input  1  serial line; idle high; externally synchronous to clk
data_out  output  data_size  last received word; LSB = first data bit received
data_valid  output  1  1-cycle pulse when data_out, parity_err and frame_err update
parity_err  output  1  parity mismatch on the last frame
frame_err  output  1  stop bit sampled 0 on the last frame
busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset (asynchronous, any time): state=IDLE, counters=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. A frame in progress is discarded with no data_valid.
- States: IDLE, START, DATA, PARITY (only when parity_on=1), STOP, WAIT_IDLE.
- IDLE: on the first rising clk edge that samples Rx_s=0, go to START and set busy=1. This edge is cycle 0 of the frame timeline.
- START: at cycle no_of_clks/2, sample Rx_s.
  - If 1: false start; return to IDLE, busy=0, no flags change.
  - If 0: go to DATA with the sampling counter cleared.
- Sample points: each subsequent sample is taken no_of_clks cycles after the previous one. With defaults, data bit i is sampled at cycle 8+16*(i+1); i=0..data_size-1.
- DATA: each sampled bit is shifted into a shift register LSB-first. A bit counter runs 0..data_size-1. After the last bit, go to PARITY (parity_on=1) or STOP.
- PARITY: sample the parity bit.
  - even_parity=1: error if XOR(data bits, parity bit) = 1.
  - even_parity=0: error if that XOR = 0.
- STOP: sample the stop bit at its mid-point (defaults: cycle 168 with parity, 152 without).
  - Next cycle: data_out is loaded, data_valid=1 for exactly one cycle, and parity_err and frame_err are loaded for this frame (parity_err forced 0 when parity_on=0).
  - If stop=1: go to IDLE and drop busy. The next start edge is accepted from the following cycle, so the back-to-back minimum is 1 stop bit.
  - If stop=0: go to WAIT_IDLE with frame_err=1.
- WAIT_IDLE: busy stays 1; hold until Rx_s=1 is sampled, then go to IDLE. This covers line breaks.
- Data is always delivered on a parity or framing error; the flags qualify it.
- Flags and data_out hold their values until the next data_valid.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, parity, stop) uses a 2-of-3 majority vote of Rx_s taken at cycles mid-1, mid and mid+1. The decision is available at mid+1, so data_valid moves 1 cycle later (cycle 170 for the default parity frame). A single-cycle glitch at mid-bit is rejected.
- Undefined: single sample at mid; timing exactly as in Behaviour.

Test Plan:
- Default params; send 0xA5 with even parity bit 0 and stop 1, 16 clks per bit -> data_valid only at cycle 169, data_out=0xA5, parity_err=0, frame_err=0, busy low at cycle 169.
- Send 0x01 with parity bit 0 (even parity needs 1) -> data_out=0x01, parity_err=1, frame_err=0. Then a clean 0x01 frame -> parity_err=0.
- Send 0x3C with stop bit 0, then hold Rx_s=0 for 64 cycles -> frame_err=1 and data_out=0x3C. No second data_valid while the line is low. After Rx_s=1, frame 0x5A is received correctly.
- Low pulse of 4 cycles on an idle line -> no data_valid; busy high for ≤ 9 cycles, then 0.
- Back-to-back frames 0x3C then 0xC3, each with a stop of exactly 16 cycles -> two data_valid pulses 176 cycles apart, with the correct data and no errors.
- Assert rst at cycle 60 of a frame for 2 cycles, then send 0x7E -> no data_valid from the aborted frame; all outputs 0 during reset; 0x7E received cleanly.

Source files
------------

// File: rtl/uart_rx_fsmd.sv
// UART receiver (controller + datapath): mid-bit sampling, LSB first, optional parity, one stop bit.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (decision one cycle later).
module uart_rx_fsmd #(
  parameter int data_size           = 8,
  parameter int parity_on           = 1,
  parameter int even_parity         = 1,
  parameter int no_of_clks          = 16,
  parameter int sampling_cntr_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_s,
  output logic [data_size-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int W = sampling_cntr_width;
  localparam logic [W-1:0] LAST = W'(no_of_clks - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [W-1:0] START_PT = W'(no_of_clks / 2 + 1);
`else
  localparam logic [W-1:0] START_PT = W'(no_of_clks / 2);
`endif
  localparam logic [3:0] LAST_BIT = 4'(data_size - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               state;
  logic [W-1:0]         cnt;
  logic [3:0]           bit_cnt;
  logic [data_size-1:0] shreg;
  logic [data_size:0]   sh_next;
  logic                 par_q;
  logic                 stop_q;
  logic                 done;
  logic                 samp;

`ifdef UART_RX_MAJORITY_EN
  // hist[1] holds the line at mid-1, hist[0] at mid; the vote completes at mid+1.
  logic [1:0] hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], Rx_s};
  end
  assign samp = (hist[1] & hist[0]) | (hist[1] & Rx_s) | (hist[0] & Rx_s);
`else
  assign samp = Rx_s;
`endif

  assign sh_next = {samp, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!Rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= W'(1);  // the detecting edge is cycle 0, so the next edge is cycle 1
          end
        end
        START: begin
          if (cnt == START_PT) begin
            cnt <= '0;
            if (samp) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= sh_next[data_size:1];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state <= (parity_on != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            par_q <= (even_parity != 0) ? (^shreg ^ samp) : ~(^shreg ^ samp);
            state <= STOP;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        STOP: begin
          if (done) begin
            // Result is published one cycle after the stop-bit decision.
            done       <= 1'b0;
            data_out   <= shreg;
            data_valid <= 1'b1;
            parity_err <= (parity_on != 0) ? par_q : 1'b0;
            frame_err  <= ~stop_q;
            cnt        <= '0;
            if (stop_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_IDLE;
            end
          end else if (cnt == LAST) begin
            stop_q <= samp;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        WAIT_IDLE: begin
          if (Rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Self-checking bench for uart_rx_fsmd with default parameters; scoreboard checks data, flags and exact valid cycle.
module tb_uart_rx_fsmd;

  localparam int NCLK = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // start mid + 10 more bit times (8 data, parity, stop) + 1 publish cycle
  localparam int DV_OFF = NCLK / 2 + NCLK * 10 + 1 + MAJ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rx_s = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  uart_rx_fsmd dut (
    .clk(clk), .rst(rst), .Rx_s(Rx_s),
    .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic pe; logic fe; int cy;} exp_t;
  typedef struct {logic [7:0] d; logic pbit; logic sbit; logic pe; logic fe;} vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer
  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_data_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", data_out, e.d);
        chk("parity_err", parity_err, e.pe);
        chk("frame_err", frame_err, e.fe);
        chk("valid_cycle", cyc, e.cy);
        chk("busy_at_valid", busy, e.fe);
      end
    end
  end

  // Called at a negedge; the next posedge is frame cycle 0.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sbit,
                            input logic pe, input logic fe, input int stop_len);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.cy = cyc + 1 + DV_OFF;
    sb.push_back(e);
    Rx_s = 1'b0;
    repeat (NCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx_s = d[i];
      repeat (NCLK) @(negedge clk);
    end
    Rx_s = pb;
    repeat (NCLK) @(negedge clk);
    Rx_s = sbit;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic idle(input int n);
    Rx_s = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_data_valid"}, data_valid, 0);
    chk({nm, "_parity_err"}, parity_err, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   bh;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0};

    rst  = 1'b1;
    Rx_s = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(5);

    foreach (vecs[k]) begin
      send_frame(vecs[k].d, vecs[k].pbit, vecs[k].sbit, vecs[k].pe, vecs[k].fe, NCLK);
      idle(4);
    end
    wait_drain(400);

    // Outputs hold until the next frame
    idle(20);
    chk("perr_hold", parity_err, 1);
    chk("data_hold", data_out, 8'h55);

    // Stop bit 0 followed by a line break
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, NCLK);
    Rx_s = 1'b0;
    repeat (64) @(negedge clk);
    chk("busy_during_break", busy, 1);
    chk("ferr_during_break", frame_err, 1);
    idle(3);
    chk("busy_after_break", busy, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, NCLK);
    idle(4);
    wait_drain(400);
    chk("ferr_cleared", frame_err, 0);

    // 4-cycle glitch on idle line
    bh   = 0;
    Rx_s = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i == 3) Rx_s = 1'b1;
      if (busy) bh++;
    end
    chk("glitch_busy_in_range", (bh >= 1 && bh <= 9), 1);
    chk("glitch_busy_low", busy, 0);

    // Back-to-back frames with a single 16-cycle stop bit
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, NCLK);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, NCLK);
    idle(4);
    wait_drain(400);

    // Reset at cycle 60 of a frame
    Rx_s = 1'b0;
    repeat (NCLK) @(negedge clk);
    Rx_s = 1'b0;
    repeat (NCLK) @(negedge clk);
    Rx_s = 1'b1;
    repeat (NCLK) @(negedge clk);
    Rx_s = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    Rx_s = 1'b1;
    #1;
    chk_zero("midframe_reset");
    repeat (2) @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    idle(20);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, NCLK);
    idle(4);
    wait_drain(400);

    idle(10);
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
